// File: rtl/alu_op_dispatcher_if.sv
// alu_op_dispatcher_if
// Command/result handshake bundle between an ALU command producer/consumer
// and alu_op_dispatcher.
//   in_valid / in_ready     : command handshake (producer -> dispatcher)
//   in_A, in_B, in_ALU_FUN  : command payload
//   out_valid / out_ready   : result handshake (dispatcher -> consumer)
//   out_result, out_err     : result payload
// Modports: master = producer/consumer side, slave = dispatcher side.
interface alu_op_dispatcher_if #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16
);
  localparam int R_W = A_WIDTH + B_WIDTH;

  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] in_A;
  logic [B_WIDTH-1:0] in_B;
  logic [3:0]         in_ALU_FUN;
  logic               out_valid;
  logic               out_ready;
  logic [R_W-1:0]     out_result;
  logic               out_err;

  modport master (
    output in_valid, in_A, in_B, in_ALU_FUN, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_A, in_B, in_ALU_FUN, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/alu_op_dispatcher.sv
// alu_op_dispatcher
// Control stage in front of four ALU execution units (arith, logic, cmp,
// shift). Accepts one command per handshake, pulses the selected unit's
// enable for one cycle, waits for that unit's Flag, captures its OUT and
// holds it on the result handshake until consumed.
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   bus             : alu_op_dispatcher_if.slave command/result handshake
//   U_A, U_B, U_FUNC: latched operands / unit function, shared by all units
//   *_Enable        : one-cycle unit enables
//   *_OUT, *_Flag   : unit results and result-valid flags
//   busy            : high whenever a command is in flight (state != IDLE)
// Optional build macro: DISPATCH_TIMEOUT_EN -- bounds the WAIT state to
// TIMEOUT_CYCLES cycles and reports an expired wait through out_err.
module alu_op_dispatcher #(
  parameter int A_WIDTH        = 16,
  parameter int B_WIDTH        = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_op_dispatcher_if.slave         bus,
  output logic [A_WIDTH-1:0]         U_A,
  output logic [B_WIDTH-1:0]         U_B,
  output logic [1:0]                 U_FUNC,
  output logic                       Arith_Enable,
  output logic                       Logic_Enable,
  output logic                       CMP_Enable,
  output logic                       Shift_Enable,
  input  logic [A_WIDTH+B_WIDTH-1:0] Arith_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] Logic_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] CMP_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] Shift_OUT,
  input  logic                       Arith_Flag,
  input  logic                       Logic_Flag,
  input  logic                       CMP_Flag,
  input  logic                       Shift_Flag,
  output logic                       busy
);
  localparam int R_W = A_WIDTH + B_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     sel_q;
  logic [3:0]     en_q;       // [0] arith, [1] logic, [2] cmp, [3] shift
  logic           vld_q;
  logic [R_W-1:0] result_q;
  logic           err_q;
  logic           sel_flag;
  logic [R_W-1:0] sel_out;
  logic           timeout_hit;

  // One-hot enable pattern for a unit select code.
  function automatic logic [3:0] unit_onehot(input logic [1:0] s);
    unit_onehot = 4'b0001 << s;
  endfunction

  // Only the latched unit's Flag/OUT are observed; the others are ignored.
  always_comb begin
    sel_flag = 1'b0;
    sel_out  = '0;
    case (sel_q)
      2'b00: begin sel_flag = Arith_Flag; sel_out = Arith_OUT; end
      2'b01: begin sel_flag = Logic_Flag; sel_out = Logic_OUT; end
      2'b10: begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
      default: begin sel_flag = Shift_Flag; sel_out = Shift_OUT; end
    endcase
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Counter holds the number of WAIT cycles already elapsed, so the limit
  // is hit on the TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout_hit = (state_q == WAIT) &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  // No counter in this build: WAIT never expires.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (sel_flag || timeout_hit) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Command latch, enable pulse and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      U_A      <= '0;
      U_B      <= '0;
      U_FUNC   <= '0;
      sel_q    <= '0;
      en_q     <= '0;
      vld_q    <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      en_q <= '0;
      if (state_q == IDLE && bus.in_valid) begin
        U_A    <= bus.in_A;
        U_B    <= bus.in_B;
        U_FUNC <= bus.in_ALU_FUN[1:0];
        sel_q  <= bus.in_ALU_FUN[3:2];
        // Enable rises together with the ISSUE state and drops after it.
        en_q   <= unit_onehot(bus.in_ALU_FUN[3:2]);
      end
      if (state_q == WAIT) begin
        // A Flag coinciding with the timeout takes priority.
        if (sel_flag) begin
          result_q <= sel_out;
          err_q    <= 1'b0;
          vld_q    <= 1'b1;
        end else if (timeout_hit) begin
          result_q <= '0;
          err_q    <= 1'b1;
          vld_q    <= 1'b1;
        end
      end
      if (state_q == DONE && bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign Arith_Enable   = en_q[0];
  assign Logic_Enable   = en_q[1];
  assign CMP_Enable     = en_q[2];
  assign Shift_Enable   = en_q[3];
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = vld_q;
  assign bus.out_result = result_q;
  assign bus.out_err    = err_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_op_dispatcher.sv
// tb_alu_op_dispatcher
// Directed-vector bench for alu_op_dispatcher with behavioural ALU unit
// models (programmable Flag delay per unit) and a result scoreboard.
module tb_alu_op_dispatcher;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_dispatcher_if #(.A_WIDTH(16), .B_WIDTH(16)) bif ();

  logic [15:0] U_A, U_B;
  logic [1:0]  U_FUNC;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [31:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic        busy;

  alu_op_dispatcher #(.A_WIDTH(16), .B_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave),
    .U_A(U_A), .U_B(U_B), .U_FUNC(U_FUNC),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .busy(busy)
  );

  // ---------------- unit models ----------------
  // dly[i]: Flag appears dly[i] cycles after the enable cycle; 0 = never.
  int          dly [4];
  int          cnt [4];
  logic        pend [4];
  logic        flag_r [4];
  logic [31:0] out_r [4];
  logic        logic_spur;
  wire  [3:0]  en_w = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

  function automatic logic [31:0] unit_f(input int u, input logic [15:0] a,
                                         input logic [15:0] b, input logic [1:0] f);
    logic [31:0] ea, eb;
    ea = {16'h0, a};
    eb = {16'h0, b};
    unit_f = 32'h0;
    case (u)
      0: case (f) 2'b00: unit_f = ea + eb; 2'b01: unit_f = ea - eb;
                  2'b10: unit_f = ea * eb; default: unit_f = 32'h0; endcase
      1: case (f) 2'b00: unit_f = ea & eb; 2'b01: unit_f = ea | eb;
                  2'b10: unit_f = ea ^ eb; default: unit_f = {16'h0, ~(a & b)}; endcase
      2: case (f) 2'b00: unit_f = {31'h0, a == b}; 2'b01: unit_f = {31'h0, a > b};
                  2'b10: unit_f = {31'h0, a < b}; default: unit_f = 32'h0; endcase
      default: case (f) 2'b00: unit_f = ea >> 1; 2'b01: unit_f = ea << 1;
                  2'b10: unit_f = ea << b[3:0]; default: unit_f = ea >> b[3:0]; endcase
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      flag_r[i] <= 1'b0;
      if (rst) begin
        pend[i] <= 1'b0;
      end else if (en_w[i]) begin
        out_r[i] <= unit_f(i, U_A, U_B, U_FUNC);
        if (dly[i] == 1) flag_r[i] <= 1'b1;
        else if (dly[i] > 1) begin pend[i] <= 1'b1; cnt[i] <= dly[i] - 1; end
      end else if (pend[i]) begin
        if (cnt[i] == 1) begin flag_r[i] <= 1'b1; pend[i] <= 1'b0; end
        else cnt[i] <= cnt[i] - 1;
      end
    end
  end

  assign Arith_OUT  = out_r[0];
  assign Logic_OUT  = out_r[1];
  assign CMP_OUT    = out_r[2];
  assign Shift_OUT  = out_r[3];
  assign Arith_Flag = flag_r[0];
  assign Logic_Flag = flag_r[1] | logic_spur;
  assign CMP_Flag   = flag_r[2];
  assign Shift_Flag = flag_r[3];

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] expq [$];   // {err, result}

  always @(negedge clk) begin
    if (!rst && bif.out_valid && bif.out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got result=%h err=%b with nothing expected",
                 bif.out_result, bif.out_err);
      end else begin
        logic [32:0] e;
        e = expq.pop_front();
        if ({bif.out_err, bif.out_result} !== e) begin
          errors++;
          $display("FAIL result got result=%h err=%b expected result=%h err=%b",
                   bif.out_result, bif.out_err, e[31:0], e[32]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                       input logic [31:0] r, input logic e, input bit push);
    int n = 0;
    while (!bif.in_ready && n < 50) begin tick(); n++; end
    chk("issue_in_ready", bif.in_ready, 1);
    bif.in_valid   = 1'b1;
    bif.in_A       = a;
    bif.in_B       = b;
    bif.in_ALU_FUN = f;
    if (push) expq.push_back({e, r});
    tick();
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!bif.out_valid && n < limit) begin tick(); n++; end
    chk("out_valid_within_budget", bif.out_valid, 1);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                     input logic [31:0] r);
    issue(a, b, f, r, 1'b0, 1'b1);
    wait_valid(40);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) dly[i] = 1;
    logic_spur     = 1'b0;
    rst            = 1'b1;
    bif.in_valid   = 1'b1;
    bif.in_A       = 16'hAAAA;
    bif.in_B       = 16'h5555;
    bif.in_ALU_FUN = 4'b0000;
    bif.out_ready  = 1'b1;
    tick();
    tick();
    chk("rst_enables", {28'h0, en_w}, 0);
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_out_result", bif.out_result, 0);
    chk("rst_out_err", bif.out_err, 0);
    chk("rst_in_ready", bif.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_U_A", U_A, 0);
    bif.in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Shift dispatch with cycle-accurate latency
    issue(16'h0003, 16'h0000, 4'b1101, 32'h6, 1'b0, 1'b1);
    chk("shift_en_c1", {28'h0, en_w}, 4'b1000);
    chk("shift_ufunc", U_FUNC, 2'b01);
    chk("shift_busy_c1", busy, 1);
    chk("shift_in_ready_c1", bif.in_ready, 0);
    tick();
    chk("shift_en_c2", {28'h0, en_w}, 0);
    chk("shift_vld_c2", bif.out_valid, 0);
    tick();
    chk("shift_vld_c3", bif.out_valid, 1);
    tick();
    chk("shift_idle_c4", bif.in_ready, 1);

    // Directed vectors across all units
    run(16'h1234, 16'h0FFF, 4'b0000, 32'h0000_2233);
    run(16'h0001, 16'h0002, 4'b0001, 32'hFFFF_FFFF);
    run(16'hFFFF, 16'hFFFF, 4'b0010, 32'hFFFE_0001);
    run(16'hF0F0, 16'h0FF0, 4'b0110, 32'h0000_FF00);
    run(16'h0005, 16'h0003, 4'b1001, 32'h0000_0001);
    run(16'h0007, 16'h0008, 4'b1000, 32'h0000_0000);
    run(16'h8001, 16'h0004, 4'b1110, 32'h0008_0010);

    // Backpressure with a pending command
    bif.out_ready = 1'b0;
    issue(16'h0002, 16'h0003, 4'b0000, 32'h5, 1'b0, 1'b1);
    bif.in_valid   = 1'b1;
    bif.in_A       = 16'h00FF;
    bif.in_B       = 16'hFF00;
    bif.in_ALU_FUN = 4'b0101;
    expq.push_back({1'b0, 32'h0000_FFFF});
    wait_valid(20);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", bif.out_valid, 1);
      chk("bp_out_result", bif.out_result, 32'h5);
      chk("bp_in_ready", bif.in_ready, 0);
      tick();
    end
    bif.out_ready = 1'b1;
    chk("bp_in_ready_release", bif.in_ready, 0);
    tick();
    chk("bp_idle_after_consume", bif.in_ready, 1);
    tick();
    chk("bp_next_logic_en", {28'h0, en_w}, 4'b0010);
    chk("bp_next_U_A", U_A, 16'h00FF);
    bif.in_valid = 1'b0;
    wait_valid(20);
    tick();

    // Non-selected flag ignored; selected flag delayed
    dly[0] = 3;
    issue(16'h0010, 16'h0020, 4'b0000, 32'h30, 1'b0, 1'b1);
    tick();
    logic_spur = 1'b1;
    tick();
    logic_spur = 1'b0;
    chk("ign_busy_c3", busy, 1);
    chk("ign_vld_c3", bif.out_valid, 0);
    tick();
    chk("ign_vld_c4", bif.out_valid, 0);
    tick();
    chk("ign_vld_c5", bif.out_valid, 1);
    tick();
    dly[0] = 1;

    // Reset during WAIT aborts the command
    dly[2] = 0;
    issue(16'h0007, 16'h0007, 4'b1000, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", bif.in_ready, 1);
    chk("mrst_enables", {28'h0, en_w}, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("mrst_no_out_valid", bif.out_valid, 0);
      tick();
    end
    dly[2] = 1;

`ifdef DISPATCH_TIMEOUT_EN
    // Flag on the last allowed WAIT cycle still wins
    dly[3] = 8;
    issue(16'h0005, 16'h0000, 4'b1101, 32'hA, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) tick();
    chk("tie_vld_c9", bif.out_valid, 0);
    tick();
    chk("tie_vld_c10", bif.out_valid, 1);
    tick();
    // No flag at all: timeout after 8 WAIT cycles
    dly[3] = 0;
    issue(16'h0005, 16'h0000, 4'b1101, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) tick();
    chk("to_vld_c9", bif.out_valid, 0);
    tick();
    chk("to_vld_c10", bif.out_valid, 1);
    chk("to_err", bif.out_err, 1);
    tick();
    dly[3] = 1;
`else
    // Without the timeout, WAIT holds until reset
    dly[3] = 0;
    issue(16'h0005, 16'h0000, 4'b1101, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    chk("nto_busy", busy, 1);
    chk("nto_vld", bif.out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("nto_idle", busy, 0);
    dly[3] = 1;
`endif

    run(16'h00F0, 16'h0F00, 4'b0101, 32'h0000_0FF0);
    tick();
    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
- Control stage directly upstream of the ALU execution units (arithmetic, logic, compare, shift). Each unit has an enable, a 2-bit function code, a registered OUT and a registered Flag.
- Accepts one ALU command per valid/ready handshake and latches operands and opcode.
- Pulses the enable and function code of exactly one selected unit, waits for that unit's Flag, captures its OUT, and holds the result on a valid/ready output port until it is consumed.

Parameters:
- A_WIDTH, 16, operand A width.
- B_WIDTH, 16, operand B width.
- TIMEOUT_CYCLES, 8, WAIT-state cycle limit; used only with DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  command valid.
- in_ready  out  1  dispatcher can accept a command.
- in_A  in  A_WIDTH  operand A.
- in_B  in  B_WIDTH  operand B.
- in_ALU_FUN  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit function.
- U_A  out  A_WIDTH  latched A, driven to all units.
- U_B  out  B_WIDTH  latched B, driven to all units.
- U_FUNC  out  2  latched in_ALU_FUN[1:0], driven to all units.
- Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  out  1 each  unit enables.
- Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  in  A_WIDTH+B_WIDTH each  unit results.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  unit result-valid flags.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  A_WIDTH+B_WIDTH  captured result.
- out_err  out  1  result produced by timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high, overrides everything) returns the block to IDLE.
  - All registered outputs clear to 0: U_A, U_B, U_FUNC, all enables, out_valid, out_result, out_err, and the latched select.
  - in_ready=1 after reset. busy=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge: latch in_A, in_B, in_ALU_FUN into U_A, U_B, U_FUNC and the select register; go to ISSUE.
  - in_valid=0: stay in IDLE.
- ISSUE:
  - Exactly one enable, chosen by the latched select, is high for exactly this one cycle. All other enables are 0.
  - Go to WAIT unconditionally.
- WAIT:
  - All enables are 0.
  - If the selected unit's Flag=1: capture the selected unit's OUT into out_result, set out_err=0, go to DONE.
  - Flags from non-selected units are ignored.
  - Otherwise stay in WAIT.
- DONE:
  - out_valid=1; out_result and out_err are held stable.
  - When out_ready=1: clear out_valid at the edge and go to IDLE.
  - out_result keeps its last value after it is consumed.
- in_ready is 1 only in IDLE. No command is accepted while busy; in_valid held high is accepted on the first IDLE cycle after DONE completes.
- U_A, U_B and U_FUNC stay stable from the ISSUE cycle until the next accept.
- Latency, with single-cycle registered units (enable sampled at edge N, Flag high in cycle N+1):
  - Accept at edge E0; ISSUE in cycle 1; WAIT in cycle 2 (Flag=1); out_valid=1 in cycle 3.
  - Minimum 4 cycles per command when out_ready=1.
- out_ready=1 in a state other than DONE has no effect.
- Reset asserted in any state aborts the command with no output handshake. Units see their enable drop and are left to settle by themselves.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If the selected Flag is still 0 when the counter reaches TIMEOUT_CYCLES: go to DONE with out_result=0 and out_err=1.
  - A Flag arriving on the same cycle as the timeout wins: the normal capture happens with out_err=0.
- Not defined: no counter is built, WAIT waits indefinitely, and out_err is tied 0.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with in_valid=1 -> all enables 0, out_valid=0, out_result=0, in_ready=1 after the reset edge.
- Shift dispatch: in_ALU_FUN=4'b1101, in_A=16'h0003; unit model returns Shift_OUT=32'h6 one cycle after enable -> Shift_Enable high exactly 1 cycle, U_FUNC=2'b01, out_valid in cycle 3, out_result=32'h6.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with a new in_valid pending -> out_result stable, in_ready=0 throughout; the new command is accepted on the cycle after out_ready=1.
- Ignored flags: select arith, Logic_Flag pulsed in WAIT, Arith_Flag delayed 3 cycles -> FSM stays in WAIT until Arith_Flag; out_result=Arith_OUT.
- Mid-operation reset: assert rst in the WAIT cycle -> next cycle IDLE, busy=0, out_valid never asserts.
- Timeout (DISPATCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=8): no Flag returned -> DONE after 8 WAIT cycles, out_result=0, out_err=1.
